operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 26 ++
 rtl/operand_fetch_reg_scoreboard.sv | 45 ++++
 rtl/operand_fetch.sv | 130 +++++++++++++
 tb/tb_operand_fetch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared processor constants and types used by the operand-fetch stage.
package operand_fetch_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;
  localparam int OP_W     = 4;
  localparam int IMM_W    = 16;
  localparam int PC_W     = 16;
  localparam int STALL_W  = 16;

  typedef enum logic {
    EX_EMPTY = 1'b0,
    EX_FULL  = 1'b1
  } ex_state_e;

  // Non-operand payload carried from decode into execute.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic [OP_W-1:0]   op;
    logic [IMM_W-1:0]  imm;
    logic [PC_W-1:0]   pc;
  } ex_ctrl_t;

endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// Per-register pending bits for issued, not-yet-written-back destinations,
// plus the RAW/WAW hazard check against the decoding instruction.
module reg_scoreboard #(
  parameter int NUM_REGS = operand_fetch_pkg::NUM_REGS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [operand_fetch_pkg::REG_AW-1:0] rs_a,
  input  logic [operand_fetch_pkg::REG_AW-1:0] rs_b,
  input  logic [operand_fetch_pkg::REG_AW-1:0] rd,
  input  logic                                rd_we,
  input  logic                                set_en,
  input  logic                                wb_valid,
  input  logic [operand_fetch_pkg::REG_AW-1:0] wb_addr,
  input  logic                                kill_en,
  input  logic [operand_fetch_pkg::REG_AW-1:0] kill_addr,
  output logic                                hazard
);
  import operand_fetch_pkg::*;

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pend_eff;
  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] kill_mask;
  logic [NUM_REGS-1:0] set_mask;

  always_comb begin
    wb_mask   = wb_valid ? (NUM_REGS'(1) << wb_addr)   : '0;
    kill_mask = kill_en  ? (NUM_REGS'(1) << kill_addr) : '0;
    set_mask  = set_en   ? (NUM_REGS'(1) << rd)        : '0;
    // A register being written back this cycle is already safe to read.
    pend_eff  = pending & ~wb_mask;
    hazard    = pend_eff[rs_a] | pend_eff[rs_b] | (rd_we & pend_eff[rd]);
  end

  // Set is applied last so a same-edge issue wins over write-back/kill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~wb_mask & ~kill_mask) | set_mask;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register-file read, write-back forwarding, scoreboard
// stalls and a single-entry registered hand-off to execute.
module operand_fetch #(
  parameter int DATA_W   = operand_fetch_pkg::DATA_W,
  parameter int NUM_REGS = operand_fetch_pkg::NUM_REGS
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    id_valid,
  output logic                                    id_ready,
  input  logic [operand_fetch_pkg::REG_AW-1:0]    id_rs_a,
  input  logic [operand_fetch_pkg::REG_AW-1:0]    id_rs_b,
  input  logic [operand_fetch_pkg::REG_AW-1:0]    id_rd,
  input  logic                                    id_rd_we,
  input  logic [operand_fetch_pkg::OP_W-1:0]      id_op,
  input  logic [operand_fetch_pkg::IMM_W-1:0]     id_imm,
  input  logic [operand_fetch_pkg::PC_W-1:0]      id_pc,
  output logic [2*operand_fetch_pkg::REG_AW-1:0]  rf_read_addr,
  input  logic [2*DATA_W-1:0]                     rf_read_data,
  input  logic                                    wb_valid,
  input  logic [operand_fetch_pkg::REG_AW-1:0]    wb_addr,
  input  logic [DATA_W-1:0]                       wb_data,
  input  logic                                    flush,
  output logic                                    ex_valid,
  input  logic                                    ex_ready,
  output logic [DATA_W-1:0]                       ex_opa,
  output logic [DATA_W-1:0]                       ex_opb,
  output logic [operand_fetch_pkg::REG_AW-1:0]    ex_rd,
  output logic                                    ex_rd_we,
  output logic [operand_fetch_pkg::OP_W-1:0]      ex_op,
  output logic [operand_fetch_pkg::IMM_W-1:0]     ex_imm,
  output logic [operand_fetch_pkg::PC_W-1:0]      ex_pc,
  output logic [operand_fetch_pkg::STALL_W-1:0]   stall_cnt
);
  import operand_fetch_pkg::*;

  ex_state_e         state;
  ex_state_e         state_n;
  ex_ctrl_t          ex_ctrl;
  logic              hazard;
  logic              accept;
  logic              kill_en;
  logic [DATA_W-1:0] opa_fwd;
  logic [DATA_W-1:0] opb_fwd;

  assign rf_read_addr = {id_rs_a, id_rs_b};

  assign ex_valid = (state == EX_FULL);
  assign ex_rd    = ex_ctrl.rd;
  assign ex_rd_we = ex_ctrl.rd_we;
  assign ex_op    = ex_ctrl.op;
  assign ex_imm   = ex_ctrl.imm;
  assign ex_pc    = ex_ctrl.pc;

  assign id_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign accept   = id_valid && id_ready;
  assign kill_en  = flush && ex_valid && ex_ctrl.rd_we;

  always_comb begin
    opa_fwd = rf_read_data[2*DATA_W-1:DATA_W];
    opb_fwd = rf_read_data[DATA_W-1:0];
    if (wb_valid && (wb_addr == id_rs_a)) opa_fwd = wb_data;
    if (wb_valid && (wb_addr == id_rs_b)) opb_fwd = wb_data;
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rs_a      (id_rs_a),
    .rs_b      (id_rs_b),
    .rd        (id_rd),
    .rd_we     (id_rd_we),
    .set_en    (accept && id_rd_we),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .kill_en   (kill_en),
    .kill_addr (ex_ctrl.rd),
    .hazard    (hazard)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EX_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      EX_EMPTY: if (accept) state_n = EX_FULL;
      EX_FULL: begin
        if (accept) begin
          state_n = EX_FULL;
        end else if (flush || ex_ready) begin
          state_n = EX_EMPTY;
        end
      end
      default: state_n = EX_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_opa  <= '0;
      ex_opb  <= '0;
      ex_ctrl <= '0;
    end else if (accept) begin
      ex_opa        <= opa_fwd;
      ex_opb        <= opb_fwd;
      ex_ctrl.rd    <= id_rd;
      ex_ctrl.rd_we <= id_rd_we;
      ex_ctrl.op    <= id_op;
      ex_ctrl.imm   <= id_imm;
      ex_ctrl.pc    <= id_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (id_valid && hazard && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and randomized checks of operand_fetch against a cycle-level
// reference model of pending registers, the execute slot and the stall count.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic        id_ready;
  logic [2:0]  id_rs_a, id_rs_b, id_rd;
  logic        id_rd_we;
  logic [3:0]  id_op;
  logic [15:0] id_imm, id_pc;
  logic [5:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [15:0] ex_opa, ex_opb;
  logic [2:0]  ex_rd;
  logic        ex_rd_we;
  logic [3:0]  ex_op;
  logic [15:0] ex_imm, ex_pc;
  logic [15:0] stall_cnt;

  operand_fetch #(
    .DATA_W   (16),
    .NUM_REGS (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_rs_a      (id_rs_a),
    .id_rs_b      (id_rs_b),
    .id_rd        (id_rd),
    .id_rd_we     (id_rd_we),
    .id_op        (id_op),
    .id_imm       (id_imm),
    .id_pc        (id_pc),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_opa       (ex_opa),
    .ex_opb       (ex_opb),
    .ex_rd        (ex_rd),
    .ex_rd_we     (ex_rd_we),
    .ex_op        (ex_op),
    .ex_imm       (ex_imm),
    .ex_pc        (ex_pc),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_pend [8];
  bit          m_exv;
  logic [15:0] m_opa, m_opb, m_imm, m_pc;
  logic [2:0]  m_rd;
  bit          m_we;
  logic [3:0]  m_op;
  int          m_stall;
  bit          m_haz;
  bit          m_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_pend[r] = 1'b0;
    m_exv = 1'b0; m_opa = '0; m_opb = '0; m_imm = '0; m_pc = '0;
    m_rd = '0; m_we = 1'b0; m_op = '0; m_stall = 0;
  endtask

  function automatic bit busy(input logic [2:0] r);
    return m_pend[r] && !(wb_valid && (wb_addr == r));
  endfunction

  task automatic model_eval();
    m_haz   = busy(id_rs_a) || busy(id_rs_b) || (id_rd_we && busy(id_rd));
    m_ready = (!m_exv || ex_ready) && !m_haz && !flush;
  endtask

  task automatic model_edge();
    bit acc;
    acc = id_valid && m_ready;
    if (wb_valid) m_pend[wb_addr] = 1'b0;
    if (flush && m_exv && m_we) m_pend[m_rd] = 1'b0;
    if (acc && id_rd_we) m_pend[id_rd] = 1'b1;
    if (id_valid && m_haz && m_stall < 65535) m_stall++;
    if (acc) begin
      m_exv = 1'b1;
      m_opa = (wb_valid && wb_addr == id_rs_a) ? wb_data : rf_read_data[31:16];
      m_opb = (wb_valid && wb_addr == id_rs_b) ? wb_data : rf_read_data[15:0];
      m_rd = id_rd; m_we = id_rd_we; m_op = id_op; m_imm = id_imm; m_pc = id_pc;
    end else if (flush || (m_exv && ex_ready)) begin
      m_exv = 1'b0;
    end
  endtask

  // Called just after a falling edge with inputs set; returns after the next falling edge.
  task automatic cycle();
    #1;
    model_eval();
    chk("id_ready", id_ready, m_ready);
    chk("rf_read_addr", rf_read_addr, {id_rs_a, id_rs_b});
    model_edge();
    @(posedge clk);
    #1;
    chk("ex_valid", ex_valid, m_exv);
    chk("stall_cnt", stall_cnt, m_stall);
    if (m_exv) begin
      chk("ex_opa", ex_opa, m_opa);
      chk("ex_opb", ex_opb, m_opb);
      chk("ex_rd", ex_rd, m_rd);
      chk("ex_rd_we", ex_rd_we, m_we);
      chk("ex_op", ex_op, m_op);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_pc", ex_pc, m_pc);
    end
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] rd, input bit we, input logic [15:0] pc);
    id_valid = v; id_rs_a = a; id_rs_b = b; id_rd = rd; id_rd_we = we;
    id_op = pc[3:0] ^ 4'h9; id_imm = pc ^ 16'h5A5A; id_pc = pc;
  endtask

  initial begin
    reset = 1'b1;
    set_id(0, 0, 0, 0, 0, 16'h0000);
    rf_read_data = '0; wb_valid = 0; wb_addr = '0; wb_data = '0;
    flush = 0; ex_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_opa", ex_opa, 0);
    chk("rst_ex_opb", ex_opb, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_rd_we", ex_rd_we, 0);
    chk("rst_stall", stall_cnt, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic operand read
    set_id(1, 1, 2, 0, 0, 16'h0001);
    rf_read_data = 32'h00AA_00BB;
    cycle();
    chk("basic_ex_valid", ex_valid, 1);
    chk("basic_opa", ex_opa, 16'h00AA);
    chk("basic_opb", ex_opb, 16'h00BB);

    // RAW stall released by write-back with forwarding
    set_id(1, 0, 0, 3, 1, 16'h0010);
    cycle();
    chk("raw_issue_rd", ex_rd, 3);
    set_id(1, 3, 0, 0, 0, 16'h0011);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("raw_stall_ready", id_ready, 0);
      chk("raw_stall_cnt", stall_cnt, i + 1);
    end
    wb_valid = 1; wb_addr = 3; wb_data = 16'h1234;
    cycle();
    wb_valid = 0;
    chk("raw_fwd_valid", ex_valid, 1);
    chk("raw_fwd_opa", ex_opa, 16'h1234);
    chk("raw_fwd_pc", ex_pc, 16'h0011);

    // Back-pressure hold, then no-bubble replacement
    ex_ready = 0;
    set_id(1, 1, 2, 0, 0, 16'h0020);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("hold_pc", ex_pc, 16'h0011);
      chk("hold_opa", ex_opa, 16'h1234);
      chk("hold_ready", id_ready, 0);
    end
    ex_ready = 1;
    cycle();
    chk("replace_valid", ex_valid, 1);
    chk("replace_pc", ex_pc, 16'h0020);

    // Same-edge set and write-back of register 4: set wins
    set_id(1, 0, 0, 4, 1, 16'h0030);
    wb_valid = 1; wb_addr = 4; wb_data = 16'hBEEF;
    cycle();
    wb_valid = 0;
    set_id(1, 4, 0, 0, 0, 16'h0031);
    cycle();
    chk("setwin_ready", id_ready, 0);
    wb_valid = 1; wb_addr = 4; wb_data = 16'h4444;
    cycle();
    wb_valid = 0;
    chk("setwin_release_opa", ex_opa, 16'h4444);

    // Flush of held writer clears its pending bit
    set_id(1, 0, 0, 5, 1, 16'h0040);
    cycle();
    ex_ready = 0;
    set_id(0, 0, 0, 0, 0, 16'h0000);
    flush = 1;
    cycle();
    flush = 0;
    chk("flush_ex_valid", ex_valid, 0);
    set_id(1, 5, 0, 0, 0, 16'h0041);
    cycle();
    chk("flush_reuse_valid", ex_valid, 1);
    chk("flush_reuse_pc", ex_pc, 16'h0041);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      set_id(($urandom % 4) != 0, 3'($urandom), 3'($urandom), 3'($urandom),
             1'($urandom), 16'($urandom));
      rf_read_data = $urandom;
      wb_valid = ($urandom % 3) == 0;
      wb_addr = 3'($urandom);
      wb_data = 16'($urandom);
      flush = ($urandom % 16) == 0;
      ex_ready = ($urandom % 4) != 0;
      cycle();
    end

    // Drain, then asynchronous reset while an instruction is held
    flush = 0; ex_ready = 1;
    set_id(0, 0, 0, 0, 0, 16'h0000);
    for (int r = 0; r < 8; r++) begin
      wb_valid = 1; wb_addr = 3'(r);
      cycle();
    end
    wb_valid = 0;
    ex_ready = 0;
    set_id(1, 0, 0, 6, 1, 16'h0050);
    cycle();
    chk("pre_reset_valid", ex_valid, 1);
    set_id(0, 0, 0, 0, 0, 16'h0000);
    reset = 1'b1;
    #1;
    chk("async_reset_valid", ex_valid, 0);
    chk("async_reset_pc", ex_pc, 0);
    chk("async_reset_stall", stall_cnt, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    ex_ready = 1;
    set_id(1, 6, 0, 0, 0, 16'h0051);
    cycle();
    chk("post_reset_accept", ex_valid, 1);
    chk("post_reset_pc", ex_pc, 16'h0051);

    // Long hazard saturates the stall counter
    set_id(1, 0, 0, 7, 1, 16'h0060);
    cycle();
    set_id(1, 7, 0, 0, 0, 16'h0061);
    for (int i = 0; i < 70000; i++) cycle();
    chk("stall_saturate", stall_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
